// File: rtl/ntt_bitrev_loader.sv
// ntt_bitrev_loader: collects one coefficient frame, reduces each beat modulo
// `mod`, and stores it at its bit-reversed index so the butterfly network can
// consume the frame as a parallel array on a valid/ready handoff.
//
// state  | meaning
// IDLE   | waiting for beat 0; config is latched and validated on that beat
// LOAD   | storing beats 1..N-1 at bitrev(k)
// FULL   | complete frame presented on rev_data, waiting for rev_ready
// ERR    | bad config or framing; held until abort or reset
module ntt_bitrev_loader #(
  parameter int DATA_W    = 8,
  parameter int MAX_N     = 8,
  parameter int LOG_MAX_N = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                array_size,
  input  logic [7:0]                bit_length,
  input  logic [DATA_W-1:0]         mod,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      rev_valid,
  input  logic                      rev_ready,
  output logic [MAX_N*DATA_W-1:0]   rev_data,
  output logic                      cfg_err,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic                   init_q, init_d;
  logic [LOG_MAX_N-1:0]   cnt_q, cnt_d;
  logic [7:0]             n_q, n_d;
  logic [7:0]             bl_q, bl_d;
  logic [DATA_W-1:0]      mod_q, mod_d;
  logic [DATA_W-1:0]      mem_q [MAX_N];
  logic [DATA_W-1:0]      mem_d [MAX_N];

  logic                   accept;
  logic                   cfg_ok;
  logic                   is_last_beat;
  logic [31:0]            pow_n;
  logic [DATA_W-1:0]      mod_sel;
  logic [DATA_W-1:0]      red;
  logic [LOG_MAX_N-1:0]   wr_addr;

  // Reverse all LOG_MAX_N bits, then shift down so only the low bl bits count.
  // The beat index is always < 2^bl, so the upper bits land as zero.
  function automatic logic [LOG_MAX_N-1:0] bitrev(input logic [LOG_MAX_N-1:0] k,
                                                  input logic [7:0] bl);
    logic [LOG_MAX_N-1:0] r;
    for (int i = 0; i < LOG_MAX_N; i++) r[i] = k[LOG_MAX_N-1-i];
    return r >> (8'(LOG_MAX_N) - bl);
  endfunction

  assign in_ready  = init_q && (state_q == S_IDLE || state_q == S_LOAD);
  assign rev_valid = (state_q == S_FULL);
  assign cfg_err   = (state_q == S_ERR);
  assign busy      = (state_q == S_LOAD || state_q == S_FULL);
  assign accept    = in_valid && in_ready;

  // Config check on the first beat, uses the live config inputs.
  always_comb begin
    pow_n  = 32'd1 << bit_length;
    cfg_ok = (pow_n == {24'd0, array_size}) && (array_size >= 8'd2) &&
             (array_size <= 8'(MAX_N)) && (mod != '0);
  end

  // Beat 0 reduces with the live modulus (it is latched on the same edge);
  // later beats use the latched one. cnt_q is 0 in IDLE, so wr_addr is 0 there.
  always_comb begin
    mod_sel      = (state_q == S_IDLE) ? mod : mod_q;
    red          = (mod_sel == '0) ? '0 : (in_data % mod_sel);
    wr_addr      = bitrev(cnt_q, bl_q);
    is_last_beat = (8'(cnt_q) == (n_q - 8'd1));
  end

  // Next-state, counter, config latch and buffer write.
  always_comb begin
    state_d = state_q;
    init_d  = 1'b1;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bl_d    = bl_q;
    mod_d   = mod_q;
    mem_d   = mem_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            n_d   = array_size;
            bl_d  = bit_length;
            mod_d = mod;
            if (!cfg_ok || in_last) begin
              state_d = S_ERR;
            end else begin
              mem_d[0] = red;
              cnt_d    = LOG_MAX_N'(1);
              state_d  = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            mem_d[wr_addr] = red;
            if (is_last_beat) begin
              cnt_d   = '0;
              state_d = in_last ? S_FULL : S_ERR;
            end else if (in_last) begin
              state_d = S_ERR;
            end else begin
              cnt_d = cnt_q + LOG_MAX_N'(1);
            end
          end
        end
        S_FULL: begin
          if (rev_ready) state_d = S_IDLE;
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  // Entries beyond the latched frame length are masked to zero.
  always_comb begin
    rev_data = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (8'(k) < n_q) rev_data[k*DATA_W +: DATA_W] = mem_q[k];
    end
  end

  // State, config and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      bl_q    <= '0;
      mod_q   <= '0;
      for (int k = 0; k < MAX_N; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bl_q    <= bl_d;
      mod_q   <= mod_d;
      for (int k = 0; k < MAX_N; k++) mem_q[k] <= mem_d[k];
    end
  end

endmodule

// File: tb/tb_ntt_bitrev_loader.sv
// Directed bench for ntt_bitrev_loader with hand-computed bit-reversed frames.
module tb_ntt_bitrev_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  array_size, bit_length, mod;
  logic        abort, in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        rev_valid, rev_ready, cfg_err, busy;
  logic [63:0] rev_data;

  logic [7:0]  vec   [8];
  logic [7:0]  exp_v [8];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ntt_bitrev_loader #(.DATA_W(8), .MAX_N(8), .LOG_MAX_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .array_size(array_size), .bit_length(bit_length),
    .mod(mod), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .rev_valid(rev_valid),
    .rev_ready(rev_ready), .rev_data(rev_data), .cfg_err(cfg_err), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(rev_data[k*8 +: 8]), 32'(exp_v[k]));
  endtask

  task automatic set_exp(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    exp_v[4] = e4; exp_v[5] = e5; exp_v[6] = e6; exp_v[7] = e7;
  endtask

  task automatic set_vec(input logic [7:0] v0, v1, v2, v3, v4, v5, v6, v7);
    vec[0] = v0; vec[1] = v1; vec[2] = v2; vec[3] = v3;
    vec[4] = v4; vec[5] = v5; vec[6] = v6; vec[7] = v7;
  endtask

  // Streams n_beats from vec; config is scrambled after beat 0 to show it is ignored.
  task automatic send_frame(input int n_beats, input logic [7:0] sz, input logic [7:0] bl,
                            input logic [7:0] md, input int last_at, input bit stall);
    array_size = sz; bit_length = bl; mod = md;
    for (int k = 0; k < n_beats; k++) begin
      if (stall && (k == 3 || k == 6)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = vec[k];
      in_last  = (k == last_at);
      @(posedge clk); #1;
      if (k == 0) begin
        array_size = 8'd6; bit_length = 8'd0; mod = 8'd3;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic handoff(input string tag);
    check({tag, "_valid"}, 32'(rev_valid), 32'd1);
    check_frame(tag);
    rev_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(rev_valid), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rev_ready = 1'b0; array_size = '0; bit_length = '0; mod = '0;
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rev_valid", 32'(rev_valid), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_frame("rst_data");
    #11 rst_n = 1'b1;
    #1 check("rdy_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("rdy_after_edge", 32'(in_ready), 32'd1);

    // N=8, mod 17, 0..7; held under rev_ready=0
    set_vec(0, 1, 2, 3, 4, 5, 6, 7);
    send_frame(8, 8, 3, 17, 7, 0);
    check("f1_valid", 32'(rev_valid), 32'd1);
    check("f1_in_ready", 32'(in_ready), 32'd0);
    check("f1_busy", 32'(busy), 32'd1);
    set_exp(0, 4, 2, 6, 1, 5, 3, 7);
    check_frame("f1");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("f1_hold_valid", 32'(rev_valid), 32'd1);
      check_frame("f1_hold");
    end
    handoff("f1_hs");
    rev_ready = 1'b0;
    check("f1_busy_idle", 32'(busy), 32'd0);

    // N=4, mod 5, {7,9,3,12}; upper entries masked
    set_vec(7, 9, 3, 12, 0, 0, 0, 0);
    send_frame(4, 4, 2, 5, 3, 0);
    set_exp(2, 3, 4, 2, 0, 0, 0, 0);
    handoff("f2");
    rev_ready = 1'b0;

    // Bad configurations on the first beat
    vec[0] = 8'd1;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: send_frame(1, 6, 3, 17, -1, 0);
        1: send_frame(1, 8, 3, 0, -1, 0);
        default: send_frame(1, 8, 2, 17, -1, 0);
      endcase
      check($sformatf("cfg%0d_err", t), 32'(cfg_err), 32'd1);
      check($sformatf("cfg%0d_rdy", t), 32'(in_ready), 32'd0);
      check($sformatf("cfg%0d_busy", t), 32'(busy), 32'd0);
      pulse_abort();
      check($sformatf("cfg%0d_abort_err", t), 32'(cfg_err), 32'd0);
      check($sformatf("cfg%0d_abort_rdy", t), 32'(in_ready), 32'd1);
    end

    // Framing errors: early in_last, missing in_last
    set_vec(0, 1, 2, 3, 4, 5, 6, 7);
    send_frame(4, 8, 3, 17, 3, 0);
    check("early_last_err", 32'(cfg_err), 32'd1);
    pulse_abort();
    send_frame(7, 8, 3, 17, -1, 0);
    check("beat6_no_err", 32'(cfg_err), 32'd0);
    in_valid = 1'b1; in_data = 8'd7; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("no_last_err", 32'(cfg_err), 32'd1);
    check("no_last_valid", 32'(rev_valid), 32'd0);
    pulse_abort();
    check("no_last_abort", 32'(cfg_err), 32'd0);

    // abort beats a simultaneous first beat
    array_size = 8'd8; bit_length = 8'd3; mod = 8'd17;
    in_valid = 1'b1; in_data = 8'd5; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_prio_busy", 32'(busy), 32'd0);
    check("abort_prio_rdy", 32'(in_ready), 32'd1);

    // Back-to-back frames, rev_ready tied high, stalls in frame A
    rev_ready = 1'b1;
    set_vec(20, 33, 5, 16, 17, 40, 1, 9);
    send_frame(8, 8, 3, 17, 7, 1);
    set_exp(3, 0, 5, 1, 16, 6, 16, 9);
    handoff("b2b_a");
    set_vec(255, 254, 1, 2, 3, 4, 5, 6);
    send_frame(8, 8, 3, 255, 7, 0);
    set_exp(0, 3, 1, 5, 254, 4, 2, 6);
    handoff("b2b_b");
    set_vec(200, 7, 0, 0, 0, 0, 0, 0);
    send_frame(2, 2, 1, 1, 1, 0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    handoff("mod1");
    rev_ready = 1'b0;

    // Asynchronous reset mid-LOAD, then a clean frame
    set_vec(0, 1, 2, 3, 4, 5, 6, 7);
    send_frame(4, 8, 3, 17, -1, 0);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdy", 32'(in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(rev_valid), 32'd0);
    check_frame("arst_data");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_rdy_back", 32'(in_ready), 32'd1);
    set_vec(8, 7, 6, 5, 4, 3, 2, 1);
    send_frame(8, 8, 3, 17, 7, 0);
    set_exp(8, 4, 6, 2, 7, 3, 5, 1);
    handoff("post_rst");
    rev_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
